// File: rtl/keccak_pkg.sv
// Shared Keccak sponge types for the squeeze-phase reader.
// Build option: SQZ_BYTE_MASK_EN makes the output length count bytes and adds a byte-keep mask.
package keccak_pkg;

    typedef logic [63:0]             lane_t;
    typedef logic [0:4][0:4][0:63]   state_t;

    localparam int RATE_LANES_SHAKE256 = 17;
    localparam int RATE_LANES_SHAKE128 = 21;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EMIT      = 2'd1,
        PERM_WAIT = 2'd2
    } sqz_state_e;

`ifdef SQZ_BYTE_MASK_EN
    // Valid-byte mask of the final word; a whole word when the length is a multiple of 8.
    function automatic logic [7:0] last_keep_mask(input logic [2:0] tail_bytes);
        logic [7:0] mask;
        if (tail_bytes == 3'd0) begin
            mask = 8'hFF;
        end else begin
            mask = (8'd1 << tail_bytes) - 8'd1;
        end
        return mask;
    endfunction
`endif

endpackage

// File: rtl/keccak_squeeze_if.sv
// Squeeze output stream: 64-bit lanes over valid/ready, with last marker.
// Build option: SQZ_BYTE_MASK_EN adds the dout_keep byte mask.
interface keccak_squeeze_if;

    logic [63:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_last;
`ifdef SQZ_BYTE_MASK_EN
    logic [7:0]  dout_keep;
`endif

    modport master (
        output dout,
        output dout_valid,
        input  dout_ready,
`ifdef SQZ_BYTE_MASK_EN
        output dout_keep,
`endif
        output dout_last
    );

    modport slave (
        input  dout,
        input  dout_valid,
        output dout_ready,
`ifdef SQZ_BYTE_MASK_EN
        input  dout_keep,
`endif
        input  dout_last
    );

endinterface

// File: rtl/keccak_squeeze_lane_mux.sv
// Selects rate lane i = A[i%5][i/5] from the 5x5x64 state; bit z of the lane is A[x][y][z].
module keccak_lane_mux
    import keccak_pkg::*;
#(
    parameter int IDX_W = 5
) (
    input  state_t           state,
    input  logic [IDX_W-1:0] lane_idx,
    output lane_t            lane
);

    logic [2:0] x_s;
    logic [2:0] y_s;

    // Lane coordinate decode and bit gather; indices past the 25 lanes read as zero.
    always_comb begin
        x_s  = 3'(lane_idx % IDX_W'(5));
        y_s  = 3'(lane_idx / IDX_W'(5));
        lane = 64'd0;
        if (lane_idx < IDX_W'(25)) begin
            for (int z = 0; z < 64; z++) begin
                lane[z] = state[x_s][y_s][z];
            end
        end else begin
            lane = 64'd0;
        end
    end

endmodule

// File: rtl/keccak_squeeze.sv
// SHAKE squeeze-phase reader: latches the permuted state and streams rate lanes, requesting permutations.
// Build option: SQZ_BYTE_MASK_EN (out_len in bytes, dout_keep on the stream interface).
module keccak_squeeze
    import keccak_pkg::*;
#(
    parameter int RATE_LANES = RATE_LANES_SHAKE256,
    parameter int LEN_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] out_len,
    input  state_t           state_in,
    output logic             perm_req,
    input  logic             perm_done,
    output logic             busy,
    keccak_squeeze_if.master dout_if
);

    localparam int IDX_W = $clog2(RATE_LANES);

    sqz_state_e       fsm_r,       fsm_nx;
    logic [IDX_W-1:0] lane_idx_r,  lane_idx_nx;
    logic [LEN_W-1:0] remaining_r, remaining_nx;
    state_t           data_r,      data_nx;
    logic [LEN_W-1:0] words_s;
    lane_t            lane_nx_s;
    logic             handshake_s;

    logic [63:0]      dout_r;
    logic             dout_valid_r;
    logic             dout_last_r;
    logic             perm_req_r;
    logic             busy_r;

`ifdef SQZ_BYTE_MASK_EN
    logic [LEN_W:0]   len_ext_s;
    logic [7:0]       keep_last_r, keep_last_nx;
    logic [7:0]       dout_keep_r;
`endif

    // Requested length converted to a word count.
    always_comb begin
`ifdef SQZ_BYTE_MASK_EN
        len_ext_s = (LEN_W+1)'(out_len) + (LEN_W+1)'(7);
        words_s   = LEN_W'(len_ext_s >> 3);
`else
        words_s   = out_len;
`endif
    end

    assign handshake_s = dout_valid_r & dout_if.dout_ready;

    // Next-state logic for the squeeze FSM, lane pointer, word budget and captured state.
    always_comb begin
        fsm_nx       = fsm_r;
        lane_idx_nx  = lane_idx_r;
        remaining_nx = remaining_r;
        data_nx      = data_r;
`ifdef SQZ_BYTE_MASK_EN
        keep_last_nx = keep_last_r;
`endif
        case (fsm_r)
            IDLE: begin
                // busy_r still covers the cycle after the last handshake, so starts there are dropped too.
                if (start && !busy_r && (out_len != LEN_W'(0))) begin
                    data_nx      = state_in;
                    lane_idx_nx  = IDX_W'(0);
                    remaining_nx = words_s;
`ifdef SQZ_BYTE_MASK_EN
                    keep_last_nx = last_keep_mask(out_len[2:0]);
`endif
                    fsm_nx       = EMIT;
                end else begin
                    fsm_nx = IDLE;
                end
            end
            EMIT: begin
                if (handshake_s) begin
                    if (remaining_r != LEN_W'(0)) begin
                        remaining_nx = remaining_r - LEN_W'(1);
                    end else begin
                        remaining_nx = LEN_W'(0);
                    end
                    lane_idx_nx = lane_idx_r + IDX_W'(1);
                    if (remaining_r <= LEN_W'(1)) begin
                        fsm_nx = IDLE;
                    end else if (lane_idx_r == IDX_W'(RATE_LANES - 1)) begin
                        fsm_nx = PERM_WAIT;
                    end else begin
                        fsm_nx = EMIT;
                    end
                end else begin
                    fsm_nx = EMIT;
                end
            end
            PERM_WAIT: begin
                if (perm_done) begin
                    data_nx     = state_in;
                    lane_idx_nx = IDX_W'(0);
                    fsm_nx      = EMIT;
                end else begin
                    fsm_nx = PERM_WAIT;
                end
            end
            default: begin
                fsm_nx = IDLE;
            end
        endcase
    end

    keccak_lane_mux #(
        .IDX_W (IDX_W)
    ) u_lane_mux (
        .state    (data_nx),
        .lane_idx (lane_idx_nx),
        .lane     (lane_nx_s)
    );

    // State register; outputs are registered from the next-state values so they change only on edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r        <= IDLE;
            lane_idx_r   <= IDX_W'(0);
            remaining_r  <= LEN_W'(0);
            data_r       <= '0;
            dout_r       <= 64'd0;
            dout_valid_r <= 1'b0;
            dout_last_r  <= 1'b0;
            perm_req_r   <= 1'b0;
            busy_r       <= 1'b0;
`ifdef SQZ_BYTE_MASK_EN
            keep_last_r  <= 8'h00;
            dout_keep_r  <= 8'h00;
`endif
        end else begin
            fsm_r        <= fsm_nx;
            lane_idx_r   <= lane_idx_nx;
            remaining_r  <= remaining_nx;
            data_r       <= data_nx;
            dout_r       <= (fsm_nx == EMIT) ? lane_nx_s : 64'd0;
            dout_valid_r <= (fsm_nx == EMIT);
            dout_last_r  <= (fsm_nx == EMIT) && (remaining_nx == LEN_W'(1));
            perm_req_r   <= (fsm_nx == PERM_WAIT);
            busy_r       <= (fsm_nx != IDLE) || (fsm_r != IDLE);
`ifdef SQZ_BYTE_MASK_EN
            keep_last_r  <= keep_last_nx;
            if (fsm_nx != EMIT) begin
                dout_keep_r <= 8'h00;
            end else if (remaining_nx == LEN_W'(1)) begin
                dout_keep_r <= keep_last_nx;
            end else begin
                dout_keep_r <= 8'hFF;
            end
`endif
        end
    end

    assign dout_if.dout       = dout_r;
    assign dout_if.dout_valid = dout_valid_r;
    assign dout_if.dout_last  = dout_last_r;
`ifdef SQZ_BYTE_MASK_EN
    assign dout_if.dout_keep  = dout_keep_r;
`endif
    assign perm_req           = perm_req_r;
    assign busy               = busy_r;

endmodule

// File: tb/tb_keccak_squeeze.sv
// Directed bench for keccak_squeeze: reset, streaming, permutation handoff, back-pressure, abort, byte mask.
module tb_keccak_squeeze;
    import keccak_pkg::*;

    localparam logic [63:0] BASE2 = 64'h0123_4567_89AB_CD00;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] out_len;
    state_t      state_in;
    logic        perm_req;
    logic        perm_done;
    logic        busy;

    keccak_squeeze_if sq_if ();

    keccak_squeeze #(
        .RATE_LANES (17),
        .LEN_W      (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .out_len   (out_len),
        .state_in  (state_in),
        .perm_req  (perm_req),
        .perm_done (perm_done),
        .busy      (busy),
        .dout_if   (sq_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    logic [63:0] got_data[$];
    logic        got_last[$];
    logic [7:0]  got_keep[$];
    int          got_cyc[$];
    int          busy_cycles;
    int          perm_req_cycles;
    int          perm_count;
    int          stall_err;
    bit          timed_out;

    // Lane A[x][y] holds base + x + 5y, bit z of the value at A[x][y][z].
    function automatic state_t mk_state(input logic [63:0] base);
        state_t s;
        logic [63:0] v;
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                v = base + 64'(x + 5 * y);
                for (int z = 0; z < 64; z++) s[x][y][z] = v[z];
            end
        end
        return s;
    endfunction

    function automatic logic [15:0] len_of(input int words);
`ifdef SQZ_BYTE_MASK_EN
        return 16'(words * 8);
`else
        return 16'(words);
`endif
    endfunction

    // Pulses start for one edge, then scrambles state_in to prove it was latched.
    task automatic do_start(input logic [15:0] len, input logic [63:0] base);
        state_in = mk_state(base);
        start    = 1'b1;
        out_len  = len;
        @(posedge clk); #1;
        start    = 1'b0;
        state_in = mk_state(64'hDEAD_BEEF_0000_0000);
    endtask

    // Records handshakes and side signals until the last word plus two trailing cycles.
    task automatic collect(input int budget, input int perm_lat, input bit rnd_ready,
                           input logic [63:0] next_base, input int restart_at);
        int          cyc;
        int          pcnt;
        int          tail;
        bit          done;
        bit          prev_stall;
        logic [63:0] prev_dout;
        got_data.delete(); got_last.delete(); got_keep.delete(); got_cyc.delete();
        busy_cycles = 0; perm_req_cycles = 0; perm_count = 0; stall_err = 0;
        cyc = 0; pcnt = 0; tail = 0; done = 1'b0; prev_stall = 1'b0; prev_dout = 64'd0;
        while (tail < 3 && cyc < budget) begin
            perm_done = 1'b0;
            start     = (cyc == restart_at);
            if (cyc == restart_at) out_len = len_of(9);
            sq_if.dout_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (busy) busy_cycles++;
            if (perm_req) begin
                perm_req_cycles++;
                pcnt++;
                if (pcnt == perm_lat) begin
                    perm_done = 1'b1;
                    state_in  = mk_state(next_base);
                    pcnt      = 0;
                    perm_count++;
                end
            end
            if (sq_if.dout_valid && !done) begin
                if (prev_stall && sq_if.dout !== prev_dout) stall_err++;
                if (sq_if.dout_ready) begin
                    got_data.push_back(sq_if.dout);
                    got_last.push_back(sq_if.dout_last);
                    got_cyc.push_back(cyc);
`ifdef SQZ_BYTE_MASK_EN
                    got_keep.push_back(sq_if.dout_keep);
`endif
                    if (sq_if.dout_last) done = 1'b1;
                end
            end
            prev_stall = sq_if.dout_valid && !sq_if.dout_ready;
            prev_dout  = sq_if.dout;
            if (done) tail++;
            @(posedge clk); #1;
            cyc++;
        end
        perm_done = 1'b0;
        start     = 1'b0;
        sq_if.dout_ready = 1'b1;
        timed_out = !done;
    endtask

    task automatic test_reset();
        n_cmp++; if (sq_if.dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", sq_if.dout_valid); end
        n_cmp++; if (sq_if.dout !== 64'd0) begin n_err++; $display("FAIL reset_dout: got %h want 0", sq_if.dout); end
        n_cmp++; if (sq_if.dout_last !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b want 0", sq_if.dout_last); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (perm_req !== 1'b0) begin n_err++; $display("FAIL reset_perm_req: got %b want 0", perm_req); end
`ifdef SQZ_BYTE_MASK_EN
        n_cmp++; if (sq_if.dout_keep !== 8'h00) begin n_err++; $display("FAIL reset_keep: got %h want 00", sq_if.dout_keep); end
`endif
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        perm_done = 1'b1;
        @(posedge clk); #1;
        perm_done = 1'b0;
        n_cmp++; if (sq_if.dout_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL stray_perm_done: got valid=%b busy=%b want 0 0", sq_if.dout_valid, busy); end
    endtask

    task automatic test_basic();
        do_start(len_of(3), 64'd0);
        collect(50, 24, 1'b0, BASE2, -1);
        n_cmp++; if (timed_out) begin n_err++; $display("FAIL basic_timeout: got timeout want completion"); end
        n_cmp++; if (got_data.size() !== 3) begin n_err++; $display("FAIL basic_count: got %0d want 3", got_data.size()); end
        for (int i = 0; i < 3 && i < got_data.size(); i++) begin
            n_cmp++; if (got_data[i] !== 64'(i) || got_cyc[i] !== i || got_last[i] !== (i == 2)) begin
                n_err++; $display("FAIL basic_word%0d: got data=%h cyc=%0d last=%b want data=%h cyc=%0d last=%b",
                                  i, got_data[i], got_cyc[i], got_last[i], 64'(i), i, (i == 2));
            end
        end
        n_cmp++; if (busy_cycles !== 4) begin n_err++; $display("FAIL basic_busy: got %0d cycles want 4", busy_cycles); end
    endtask

    task automatic test_full_block();
        do_start(len_of(17), 64'd0);
        collect(80, 24, 1'b0, BASE2, 3);
        n_cmp++; if (got_data.size() !== 17) begin n_err++; $display("FAIL block_count: got %0d want 17", got_data.size()); end
        for (int i = 0; i < 17 && i < got_data.size(); i++) begin
            n_cmp++; if (got_data[i] !== 64'(i) || got_last[i] !== (i == 16)) begin
                n_err++; $display("FAIL block_word%0d: got data=%h last=%b want data=%h last=%b",
                                  i, got_data[i], got_last[i], 64'(i), (i == 16));
            end
        end
        n_cmp++; if (perm_req_cycles !== 0) begin n_err++; $display("FAIL block_perm_req: got %0d cycles want 0", perm_req_cycles); end
    endtask

    task automatic test_perm();
        logic [63:0] exp;
        do_start(len_of(20), 64'd0);
        collect(200, 24, 1'b0, BASE2, -1);
        n_cmp++; if (timed_out) begin n_err++; $display("FAIL perm_timeout: got timeout want completion"); end
        n_cmp++; if (got_data.size() !== 20) begin n_err++; $display("FAIL perm_count: got %0d want 20", got_data.size()); end
        for (int i = 0; i < 20 && i < got_data.size(); i++) begin
            exp = (i < 17) ? 64'(i) : BASE2 + 64'(i - 17);
            n_cmp++; if (got_data[i] !== exp || got_last[i] !== (i == 19)) begin
                n_err++; $display("FAIL perm_word%0d: got data=%h last=%b want data=%h last=%b",
                                  i, got_data[i], got_last[i], exp, (i == 19));
            end
        end
        n_cmp++; if (perm_req_cycles !== 24 || perm_count !== 1) begin
            n_err++; $display("FAIL perm_req_hold: got %0d cycles %0d perms want 24 cycles 1 perm", perm_req_cycles, perm_count);
        end
        if (got_cyc.size() > 17) begin
            n_cmp++; if (got_cyc[17] !== 41) begin n_err++; $display("FAIL perm_gap: got cycle %0d want 41", got_cyc[17]); end
        end
    endtask

    task automatic test_backpressure();
        do_start(len_of(5), 64'd0);
        collect(300, 24, 1'b1, BASE2, -1);
        n_cmp++; if (got_data.size() !== 5) begin n_err++; $display("FAIL bp_count: got %0d want 5", got_data.size()); end
        for (int i = 0; i < 5 && i < got_data.size(); i++) begin
            n_cmp++; if (got_data[i] !== 64'(i)) begin n_err++; $display("FAIL bp_word%0d: got %h want %h", i, got_data[i], 64'(i)); end
        end
        n_cmp++; if (stall_err !== 0) begin n_err++; $display("FAIL bp_stable: got %0d changes while stalled want 0", stall_err); end
    endtask

    task automatic test_zero_len_and_abort();
        start = 1'b1; out_len = 16'd0; state_in = mk_state(64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (sq_if.dout_valid !== 1'b0 || busy !== 1'b0) begin
                n_err++; $display("FAIL zero_len_c%0d: got valid=%b busy=%b want 0 0", i, sq_if.dout_valid, busy);
            end
            @(posedge clk); #1;
        end
        do_start(len_of(3), 64'd0);
        @(posedge clk); #1;
        n_cmp++; if (sq_if.dout_valid !== 1'b1 || sq_if.dout !== 64'd1) begin
            n_err++; $display("FAIL abort_pre: got valid=%b dout=%h want 1 %h", sq_if.dout_valid, sq_if.dout, 64'd1);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (sq_if.dout_valid !== 1'b0 || sq_if.dout !== 64'd0 || sq_if.dout_last !== 1'b0
                     || busy !== 1'b0 || perm_req !== 1'b0) begin
            n_err++; $display("FAIL abort_outputs: got valid=%b dout=%h last=%b busy=%b req=%b want all 0",
                              sq_if.dout_valid, sq_if.dout, sq_if.dout_last, busy, perm_req);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        do_start(len_of(2), 64'd0);
        collect(50, 24, 1'b0, BASE2, -1);
        n_cmp++; if (got_data.size() !== 2) begin n_err++; $display("FAIL restart_count: got %0d want 2", got_data.size()); end
        for (int i = 0; i < 2 && i < got_data.size(); i++) begin
            n_cmp++; if (got_data[i] !== 64'(i)) begin n_err++; $display("FAIL restart_word%0d: got %h want %h", i, got_data[i], 64'(i)); end
        end
    endtask

`ifdef SQZ_BYTE_MASK_EN
    task automatic test_byte_mask();
        do_start(16'd13, 64'd0);
        collect(50, 24, 1'b0, BASE2, -1);
        n_cmp++; if (got_keep.size() !== 2) begin n_err++; $display("FAIL keep13_count: got %0d want 2", got_keep.size()); end
        if (got_keep.size() == 2) begin
            n_cmp++; if (got_keep[0] !== 8'hFF || got_keep[1] !== 8'h1F || got_last[1] !== 1'b1) begin
                n_err++; $display("FAIL keep13: got %h %h last=%b want FF 1F 1", got_keep[0], got_keep[1], got_last[1]);
            end
        end
        do_start(16'd16, 64'd0);
        collect(50, 24, 1'b0, BASE2, -1);
        n_cmp++; if (got_keep.size() !== 2) begin n_err++; $display("FAIL keep16_count: got %0d want 2", got_keep.size()); end
        if (got_keep.size() == 2) begin
            n_cmp++; if (got_keep[0] !== 8'hFF || got_keep[1] !== 8'hFF) begin
                n_err++; $display("FAIL keep16: got %h %h want FF FF", got_keep[0], got_keep[1]);
            end
        end
    endtask
`endif

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; start = 1'b0; out_len = 16'd0; perm_done = 1'b0;
        state_in = mk_state(64'd0);
        sq_if.dout_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_full_block();
        test_perm();
        test_backpressure();
        test_zero_len_and_abort();
`ifdef SQZ_BYTE_MASK_EN
        test_byte_mask();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
